// File: rtl/mrd_pkg.sv
// Shared definitions for the mixed-radix DFT memory blocks.
// Bank/lane counts, top-FSM state encoding, lane bundle payload and
// the lane-active qualifier shared by the read engine.
package mrd_pkg;

    localparam int unsigned NUM_BANK   = 7;
    localparam int unsigned NUM_LANE   = 5;
    localparam int unsigned BANK_W     = 3;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned LANE_WDATA = 16;
    localparam int unsigned LANE_WADDR = 8;

    // Top-level FSM states driven on the fsm bus
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SINK        = 3'd1,
        WAIT_TO_RD  = 3'd2,
        RD          = 3'd3,
        WAIT_WR_END = 3'd4,
        SOURCE      = 3'd5
    } fsm_state_e;

    // One lane of a point bundle
    typedef struct packed {
        logic [BANK_W-1:0]     bank_index;
        logic [LANE_WADDR-1:0] bank_addr;
        logic [LANE_WDATA-1:0] d_real;
        logic [LANE_WDATA-1:0] d_imag;
    } lane_t;

    // A lane is live only when enabled and pointing at a real bank (index 7 disables)
    function automatic logic lane_active(input logic en, input logic [BANK_W-1:0] idx);
        return en && (idx <= BANK_W'(NUM_BANK - 1));
    endfunction

endpackage

// File: rtl/mrd_lane_steer.sv
// Per-lane 7:1 bank-data selector with a zero path for inactive lanes.
// Ports: bank_sel/active pick the source bank; dout_* are the raw bank
// outputs; d_*_c is the combinational lane result.
module mrd_lane_steer
    import mrd_pkg::*;
#(
    parameter int unsigned WDATA = 16
) (
    input  logic [BANK_W-1:0]               bank_sel,
    input  logic                            active,
    input  logic [NUM_BANK-1:0][WDATA-1:0]  dout_real,
    input  logic [NUM_BANK-1:0][WDATA-1:0]  dout_imag,
    output logic [WDATA-1:0]                d_real_c,
    output logic [WDATA-1:0]                d_imag_c
);

    always_comb begin
        d_real_c = '0;
        d_imag_c = '0;
        if (active && (bank_sel < BANK_W'(NUM_BANK))) begin
            d_real_c = dout_real[bank_sel];
            d_imag_c = dout_imag[bank_sel];
        end
    end

endmodule

// File: rtl/mrd_fsmrd_rd.sv
// Bank-read engine: issues up to five lane requests per cycle to seven RAM
// banks during Rd and re-steers returned data into lane order.
// Ports: clk/rst; fsm state; req_* lane request bundle; rden/rdaddr to banks;
// dout_* from banks; out_valid/d_* lane data; bank_conflict sticky flag;
// rd_ongoing(_r) issue history; rd_done end-of-read-phase pulse.
module mrd_fsmrd_rd
    import mrd_pkg::*;
#(
    parameter int unsigned WDATA  = 16,
    parameter int unsigned WADDR  = 8,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [2:0]                       fsm,
    input  logic                             req_valid,
    input  logic [NUM_LANE-1:0]              req_lane_en,
    input  logic [NUM_LANE-1:0][BANK_W-1:0]  req_bank_index,
    input  logic [NUM_LANE-1:0][WADDR-1:0]   req_bank_addr,
    output logic [NUM_BANK-1:0]              rden,
    output logic [NUM_BANK-1:0][WADDR-1:0]   rdaddr,
    input  logic [NUM_BANK-1:0][WDATA-1:0]   dout_real,
    input  logic [NUM_BANK-1:0][WDATA-1:0]   dout_imag,
    output logic                             out_valid,
    output logic [NUM_LANE-1:0][WDATA-1:0]   d_real,
    output logic [NUM_LANE-1:0][WDATA-1:0]   d_imag,
    output logic                             bank_conflict,
    output logic                             rd_ongoing,
    output logic                             rd_ongoing_r,
    output logic                             rd_done
);

    logic                             live;
    logic [NUM_LANE-1:0]              lane_act_c;
    logic [NUM_BANK-1:0]              rden_c;
    logic [NUM_BANK-1:0][WADDR-1:0]   rdaddr_c;
    logic                             conflict_c;
    logic [CNT_W-1:0]                 inflight;
    logic [CNT_W-1:0]                 inflight_nxt;
    logic                             seen;
    logic                             done_c;

    // Steering delay line: stage 0 aligns with rden, stage RD_LAT with dout
    logic [NUM_LANE-1:0][BANK_W-1:0]  idx_pipe  [RD_LAT+1];
    logic [NUM_LANE-1:0]              mask_pipe [RD_LAT+1];
    logic [RD_LAT:0]                  vld_pipe;

    logic [NUM_LANE-1:0][WDATA-1:0]   steer_real;
    logic [NUM_LANE-1:0][WDATA-1:0]   steer_imag;

    assign live = req_valid && (fsm == RD);

    always_comb begin
        lane_act_c = '0;
        for (int k = 0; k < int'(NUM_LANE); k++) begin
            lane_act_c[k] = live && lane_active(req_lane_en[k], req_bank_index[k]);
        end
    end

    // Bank issue: highest lane scanned first so the lowest lane's address lands last
    always_comb begin
        rden_c     = '0;
        rdaddr_c   = '0;
        conflict_c = 1'b0;
        for (int b = 0; b < int'(NUM_BANK); b++) begin
            for (int k = int'(NUM_LANE) - 1; k >= 0; k--) begin
                if (lane_act_c[k] && (req_bank_index[k] == BANK_W'(b))) begin
                    if (rden_c[b]) begin
                        conflict_c = 1'b1;
                    end
                    rden_c[b]   = 1'b1;
                    rdaddr_c[b] = req_bank_addr[k];
                end
            end
        end
    end

    // Done fires off the next count so it lands the cycle after the last out_valid
    assign inflight_nxt = inflight + CNT_W'(live) - CNT_W'(out_valid);
    assign done_c       = (fsm != RD) && (inflight_nxt == '0) && seen;

    for (genvar k = 0; k < NUM_LANE; k++) begin : g_lane
        mrd_lane_steer #(
            .WDATA     (WDATA)
        ) u_steer (
            .bank_sel  (idx_pipe[RD_LAT][k]),
            .active    (mask_pipe[RD_LAT][k]),
            .dout_real (dout_real),
            .dout_imag (dout_imag),
            .d_real_c  (steer_real[k]),
            .d_imag_c  (steer_imag[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rden          <= '0;
            rdaddr        <= '0;
            bank_conflict <= 1'b0;
            out_valid     <= 1'b0;
            d_real        <= '0;
            d_imag        <= '0;
            rd_ongoing    <= 1'b0;
            rd_ongoing_r  <= 1'b0;
            rd_done       <= 1'b0;
            inflight      <= '0;
            seen          <= 1'b0;
            vld_pipe      <= '0;
            for (int s = 0; s <= int'(RD_LAT); s++) begin
                idx_pipe[s]  <= '0;
                mask_pipe[s] <= '0;
            end
        end else begin
            rden          <= rden_c;
            rdaddr        <= rdaddr_c;
            bank_conflict <= bank_conflict | conflict_c;
            out_valid     <= vld_pipe[RD_LAT];
            d_real        <= steer_real;
            d_imag        <= steer_imag;
            rd_ongoing    <= live;
            rd_ongoing_r  <= rd_ongoing;
            rd_done       <= done_c;
            inflight      <= inflight_nxt;
            if (live) begin
                seen <= 1'b1;
            end else if (done_c) begin
                seen <= 1'b0;
            end
            vld_pipe      <= {vld_pipe[RD_LAT-1:0], live};
            idx_pipe[0]   <= req_bank_index;
            mask_pipe[0]  <= lane_act_c;
            for (int s = 1; s <= int'(RD_LAT); s++) begin
                idx_pipe[s]  <= idx_pipe[s-1];
                mask_pipe[s] <= mask_pipe[s-1];
            end
        end
    end

endmodule

// File: tb/tb_mrd_fsmrd_rd.sv
// Self-checking bench for mrd_fsmrd_rd: table-driven request vectors, a RAM
// model returning the address as real data, and a scoreboard of expected
// issue-stage and lane outputs.
module tb_mrd_fsmrd_rd;
    import mrd_pkg::*;

    localparam int unsigned WDATA  = 16;
    localparam int unsigned WADDR  = 8;
    localparam int unsigned RD_LAT = 2;

    logic                             clk;
    logic                             rst;
    logic [2:0]                       fsm;
    logic                             req_valid;
    logic [NUM_LANE-1:0]              req_lane_en;
    logic [NUM_LANE-1:0][BANK_W-1:0]  req_bank_index;
    logic [NUM_LANE-1:0][WADDR-1:0]   req_bank_addr;
    logic [NUM_BANK-1:0]              rden;
    logic [NUM_BANK-1:0][WADDR-1:0]   rdaddr;
    logic [NUM_BANK-1:0][WDATA-1:0]   dout_real;
    logic [NUM_BANK-1:0][WDATA-1:0]   dout_imag;
    logic                             out_valid;
    logic [NUM_LANE-1:0][WDATA-1:0]   d_real;
    logic [NUM_LANE-1:0][WDATA-1:0]   d_imag;
    logic                             bank_conflict;
    logic                             rd_ongoing;
    logic                             rd_ongoing_r;
    logic                             rd_done;

    mrd_fsmrd_rd #(
        .WDATA          (WDATA),
        .WADDR          (WADDR),
        .RD_LAT         (RD_LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fsm            (fsm),
        .req_valid      (req_valid),
        .req_lane_en    (req_lane_en),
        .req_bank_index (req_bank_index),
        .req_bank_addr  (req_bank_addr),
        .rden           (rden),
        .rdaddr         (rdaddr),
        .dout_real      (dout_real),
        .dout_imag      (dout_imag),
        .out_valid      (out_valid),
        .d_real         (d_real),
        .d_imag         (d_imag),
        .bank_conflict  (bank_conflict),
        .rd_ongoing     (rd_ongoing),
        .rd_ongoing_r   (rd_ongoing_r),
        .rd_done        (rd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: real = address, imag = bank*256 + address; junk when not enabled
    logic [NUM_BANK-1:0][WDATA-1:0] ram_re_c, ram_im_c;
    logic [NUM_BANK-1:0][WDATA-1:0] rp_re [RD_LAT];
    logic [NUM_BANK-1:0][WDATA-1:0] rp_im [RD_LAT];

    always_comb begin
        for (int b = 0; b < int'(NUM_BANK); b++) begin
            ram_re_c[b] = rden[b] ? 16'(rdaddr[b]) : 16'hDEAD;
            ram_im_c[b] = rden[b] ? (16'(b * 256) | 16'(rdaddr[b])) : 16'hBEEF;
        end
    end

    always @(posedge clk) begin
        rp_re[0] <= ram_re_c;
        rp_im[0] <= ram_im_c;
        for (int s = 1; s < int'(RD_LAT); s++) begin
            rp_re[s] <= rp_re[s-1];
            rp_im[s] <= rp_im[s-1];
        end
    end

    assign dout_real = rp_re[RD_LAT-1];
    assign dout_imag = rp_im[RD_LAT-1];

    typedef struct {
        logic [NUM_LANE-1:0]             en;
        logic [NUM_LANE-1:0][2:0]        idx;
        logic [NUM_LANE-1:0][7:0]        addr;
        logic [NUM_BANK-1:0]             rden;
        logic                            conf;
        logic [NUM_LANE-1:0][15:0]       dre;
    } vec_t;

    typedef struct {
        int                              cyc;
        logic [NUM_BANK-1:0]             rden;
        logic [NUM_BANK-1:0][7:0]        rdaddr;
        logic                            conf;
    } iss_t;

    typedef struct {
        int                              cyc;
        logic [NUM_LANE-1:0][15:0]       re;
        logic [NUM_LANE-1:0][15:0]       im;
    } sb_t;

    iss_t iss_q[$];
    sb_t  sb[$];
    iss_t ie;
    sb_t  se;
    vec_t tbl[6];
    vec_t vz;
    vec_t bv;

    int   checks = 0;
    int   fails  = 0;
    int   ov_cnt = 0;
    int   done_cnt = 0;
    int   last_ov = 0;
    logic conf_sticky = 1'b0;
    logic mon_en = 1'b0;
    logic exp_on;
    logic prev_on = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic lane_on(input vec_t v, input int k);
        return v.en[k] && (v.idx[k] != 3'd7);
    endfunction

    // Lowest enabled lane hitting a bank supplies that bank's address
    function automatic logic [NUM_BANK-1:0][7:0] exp_rdaddr(input vec_t v);
        logic [NUM_BANK-1:0][7:0] r;
        logic [NUM_BANK-1:0]      got;
        r   = '0;
        got = '0;
        for (int k = 0; k < int'(NUM_LANE); k++) begin
            if (lane_on(v, k) && !got[v.idx[k]]) begin
                got[v.idx[k]] = 1'b1;
                r[v.idx[k]]   = v.addr[k];
            end
        end
        return r;
    endfunction

    function automatic logic [NUM_LANE-1:0][15:0] exp_imag(input vec_t v);
        logic [NUM_LANE-1:0][15:0] r;
        r = '0;
        for (int k = 0; k < int'(NUM_LANE); k++) begin
            if (lane_on(v, k)) r[k] = (16'(v.idx[k]) << 8) | v.dre[k];
        end
        return r;
    endfunction

    // Drive one cycle of request; push expectations when the request is live
    task automatic send(input vec_t v, input logic [2:0] st, input logic vld);
        iss_t ei;
        sb_t  es;
        @(posedge clk);
        #1;
        fsm            = st;
        req_valid      = vld;
        req_lane_en    = v.en;
        req_bank_index = v.idx;
        req_bank_addr  = v.addr;
        if (vld && (st == 3'(RD))) begin
            conf_sticky = conf_sticky | v.conf;
            ei.cyc    = cyc + 1;
            ei.rden   = v.rden;
            ei.rdaddr = exp_rdaddr(v);
            ei.conf   = conf_sticky;
            iss_q.push_back(ei);
            es.cyc = cyc + 2 + int'(RD_LAT);
            es.re  = v.dre;
            es.im  = exp_imag(v);
            sb.push_back(es);
        end
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            prev_on = 1'b0;
        end else if (mon_en) begin
            exp_on = 1'b0;
            if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
                ie = iss_q.pop_front();
                exp_on = 1'b1;
                check("rden", 128'(rden), 128'(ie.rden));
                check("rdaddr", 128'(rdaddr), 128'(ie.rdaddr));
                check("bank_conflict", 128'(bank_conflict), 128'(ie.conf));
            end else begin
                check("rden_idle", 128'(rden), 128'(0));
            end
            check("rd_ongoing", 128'(rd_ongoing), 128'(exp_on));
            check("rd_ongoing_r", 128'(rd_ongoing_r), 128'(prev_on));
            prev_on = exp_on;

            if (out_valid) begin
                ov_cnt++;
                last_ov = cyc;
                if (sb.size() == 0) begin
                    check("out_valid_unexpected", 128'(1), 128'(0));
                end else begin
                    se = sb.pop_front();
                    check("latency", 128'(cyc), 128'(se.cyc));
                    check("d_real", 128'(d_real), 128'(se.re));
                    check("d_imag", 128'(d_imag), 128'(se.im));
                end
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                se = sb.pop_front();
                check("out_valid_missing", 128'(0), 128'(1));
            end

            if (rd_done) begin
                done_cnt++;
                check("rd_done_timing", 128'(cyc), 128'(last_ov + 1));
                check("rd_done_drained", 128'(sb.size()), 128'(0));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_rden"}, 128'(rden), 128'(0));
        check({tag, "_rdaddr"}, 128'(rdaddr), 128'(0));
        check({tag, "_d_real"}, 128'(d_real), 128'(0));
        check({tag, "_d_imag"}, 128'(d_imag), 128'(0));
        check({tag, "_flags"}, 128'({out_valid, bank_conflict, rd_ongoing, rd_ongoing_r, rd_done}), 128'(0));
    endtask

    int ov0, done0;

    initial begin
        vz  = '{en: '0, idx: '0, addr: '0, rden: '0, conf: 1'b0, dre: '0};
        // radix-5, banks 0..4
        tbl[0] = '{en: 5'b11111, idx: {3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
                   addr: {8'd14, 8'd13, 8'd12, 8'd11, 8'd10}, rden: 7'b0011111, conf: 1'b0,
                   dre: {16'd14, 16'd13, 16'd12, 16'd11, 16'd10}};
        // radix-3, banks {6,2,5}, lanes 3-4 disabled
        tbl[1] = '{en: 5'b00111, idx: {3'd0, 3'd1, 3'd5, 3'd2, 3'd6},
                   addr: {8'd51, 8'd50, 8'd42, 8'd41, 8'd40}, rden: 7'b1100100, conf: 1'b0,
                   dre: {16'd0, 16'd0, 16'd42, 16'd41, 16'd40}};
        // lane 3 carries index 7 and must stay silent
        tbl[2] = '{en: 5'b11111, idx: {3'd6, 3'd7, 3'd5, 3'd3, 3'd1},
                   addr: {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, rden: 7'b1101010, conf: 1'b0,
                   dre: {16'd5, 16'd0, 16'd3, 16'd2, 16'd1}};
        // lanes 0 and 2 collide on bank 3
        tbl[3] = '{en: 5'b00101, idx: {3'd0, 3'd0, 3'd3, 3'd0, 3'd3},
                   addr: {8'd0, 8'd0, 8'd30, 8'd99, 8'd20}, rden: 7'b0001000, conf: 1'b1,
                   dre: {16'd0, 16'd0, 16'd20, 16'd0, 16'd20}};
        // clean radix-4 after the conflict
        tbl[4] = '{en: 5'b01111, idx: {3'd0, 3'd3, 3'd4, 3'd5, 3'd6},
                   addr: {8'd0, 8'd103, 8'd102, 8'd101, 8'd100}, rden: 7'b1111000, conf: 1'b0,
                   dre: {16'd0, 16'd103, 16'd102, 16'd101, 16'd100}};
        // all lanes on bank 2
        tbl[5] = '{en: 5'b11111, idx: {5{3'd2}},
                   addr: {8'd11, 8'd10, 8'd9, 8'd8, 8'd7}, rden: 7'b0000100, conf: 1'b1,
                   dre: {5{16'd7}}};

        rst            = 1'b1;
        fsm            = 3'(IDLE);
        req_valid      = 1'b0;
        req_lane_en    = '0;
        req_bank_index = '0;
        req_bank_addr  = '0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        rst    = 1'b0;
        mon_en = 1'b1;

        // Table vectors back-to-back while in Rd
        for (int i = 0; i < 6; i++) send(tbl[i], 3'(RD), 1'b1);
        for (int i = 0; i < 10; i++) send(vz, 3'(IDLE), 1'b0);
        check("table_ov_count", 128'(ov_cnt), 128'(6));
        check("table_done_count", 128'(done_cnt), 128'(1));

        // Eight back-to-back bundles, then Wait_wr_end with requests still present
        ov0   = ov_cnt;
        done0 = done_cnt;
        for (int i = 0; i < 8; i++) begin
            bv = vz;
            bv.en = 5'b11111;
            for (int k = 0; k < int'(NUM_LANE); k++) begin
                bv.idx[k]  = 3'((i + k) % 7);
                bv.addr[k] = 8'(i * 16 + k);
                bv.dre[k]  = 16'(i * 16 + k);
                bv.rden[(i + k) % 7] = 1'b1;
            end
            send(bv, 3'(RD), 1'b1);
        end
        for (int i = 0; i < 4; i++) send(bv, 3'(WAIT_WR_END), 1'b1);
        for (int i = 0; i < 10; i++) send(vz, 3'(WAIT_WR_END), 1'b0);
        check("burst_ov_count", 128'(ov_cnt - ov0), 128'(8));
        check("burst_done_count", 128'(done_cnt - done0), 128'(1));

        // Asynchronous reset two cycles after a request
        ov0   = ov_cnt;
        done0 = done_cnt;
        send(tbl[0], 3'(RD), 1'b1);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        iss_q.delete();
        sb.delete();
        conf_sticky    = 1'b0;
        req_valid      = 1'b0;
        fsm            = 3'(IDLE);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(vz, 3'(RD), 1'b0);
        for (int i = 0; i < 12; i++) send(vz, 3'(IDLE), 1'b0);
        check("post_rst_ov_count", 128'(ov_cnt - ov0), 128'(0));
        check("post_rst_done_count", 128'(done_cnt - done0), 128'(0));

        check("issue_queue_empty", 128'(iss_q.size()), 128'(0));
        check("scoreboard_empty", 128'(sb.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
